// File: rtl/sumador_serial.sv
`default_nettype none
// ============================================================================
// Module   : sumador_serial
// Purpose  : Multi-cycle adder/subtractor, BITS_POR_CICLO bits per clock,
//            with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sumador_serial #(
  parameter int ANCHO          = 8,
  parameter int BITS_POR_CICLO = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic             resta,
  input  logic [ANCHO-1:0] entrada1,
  input  logic [ANCHO-1:0] entrada2,
  input  logic             entAcarreo,
  output logic [ANCHO-1:0] suma,
  output logic             acarreo,
  output logic             desbordamiento,
  output logic             ocupado,
  output logic             listo
);

  localparam int B     = BITS_POR_CICLO;
  localparam int N     = ANCHO / BITS_POR_CICLO;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N - 1);

  if ((ANCHO < 2) || (B < 1) || ((ANCHO % B) != 0)) begin : g_param_error
    $error("sumador_serial: ANCHO must be >= 2 and a multiple of BITS_POR_CICLO");
  end

  typedef enum logic [0:0] {
    REPOSO  = 1'b0,
    SUMANDO = 1'b1
  } estado_t;

  estado_t          estado;
  estado_t          estado_sig;
  logic [ANCHO-1:0] op_a;
  logic [ANCHO-1:0] op_b;
  logic [ANCHO-1:0] res_sh;
  logic [ANCHO-1:0] res_sig;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [B:0]       tramo;
  logic             aceptar;
  logic             ultimo;

  // Operands shift right each cycle, so the active slice is always the low B bits.
  assign tramo = {1'b0, op_a[B-1:0]} + {1'b0, op_b[B-1:0]} + {{B{1'b0}}, carry};

  // Slice sums enter at the top of the result register and move down.
  if (N == 1) begin : g_res_single
    assign res_sig = tramo[B-1:0];
  end else begin : g_res_multi
    assign res_sig = {tramo[B-1:0], res_sh[ANCHO-1:B]};
  end

  assign ocupado = (estado == SUMANDO);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    aceptar    = 1'b0;
    ultimo     = 1'b0;
    case (estado)
      REPOSO: begin
        if (inicio) begin
          aceptar    = 1'b1;
          estado_sig = SUMANDO;
        end
      end
      SUMANDO: begin
        if (cnt == ULTIMO) begin
          ultimo     = 1'b1;
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a           <= '0;
      op_b           <= '0;
      res_sh         <= '0;
      carry          <= 1'b0;
      cnt            <= '0;
      suma           <= '0;
      acarreo        <= 1'b0;
      desbordamiento <= 1'b0;
      listo          <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (aceptar) begin
        // Subtraction is A + ~B + ~borrow_in, so acarreo=1 means no borrow.
        op_a  <= entrada1;
        op_b  <= resta ? ~entrada2 : entrada2;
        carry <= entAcarreo ^ resta;
        cnt   <= '0;
      end else if (estado == SUMANDO) begin
        op_a   <= op_a >> B;
        op_b   <= op_b >> B;
        carry  <= tramo[B];
        res_sh <= res_sig;
        cnt    <= cnt + 1'b1;
        if (ultimo) begin
          suma           <= res_sig;
          acarreo        <= tramo[B];
          desbordamiento <= (op_a[B-1] == op_b[B-1]) && (tramo[B-1] != op_a[B-1]);
          listo          <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sumador_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sumador_serial
// Purpose  : Directed and random checks of sumador_serial (8x1 and 16x4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sumador_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        ini8 = 1'b0, resta8 = 1'b0, ci8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        c8, v8, oc8, ls8;

  logic        ini16 = 1'b0, resta16 = 1'b0, ci16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        c16, v16, oc16, ls16;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sumador_serial dut8 (
    .clk(clk), .rst(rst), .inicio(ini8), .resta(resta8),
    .entrada1(a8), .entrada2(b8), .entAcarreo(ci8),
    .suma(s8), .acarreo(c8), .desbordamiento(v8), .ocupado(oc8), .listo(ls8)
  );

  sumador_serial #(.ANCHO(16), .BITS_POR_CICLO(4)) dut16 (
    .clk(clk), .rst(rst), .inicio(ini16), .resta(resta16),
    .entrada1(a16), .entrada2(b16), .entAcarreo(ci16),
    .suma(s16), .acarreo(c16), .desbordamiento(v16), .ocupado(oc16), .listo(ls16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait8(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ls8 && n < 20);
    if (!ls8) n = 99;
  endtask

  task automatic wait16(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ls16 && n < 20);
    if (!ls16) n = 99;
  endtask

  task automatic op8(input string tag, input logic r, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic [7:0] es, input logic ec, input logic ev);
    int n;
    resta8 = r; a8 = a; b8 = b; ci8 = ci; ini8 = 1'b1;
    tick();
    chk({tag, "_ocupado"}, 32'(oc8), 32'd1);
    ini8 = 1'b0; a8 = ~a; b8 = 8'h5A; ci8 = ~ci; resta8 = ~r;
    wait8(n);
    chk({tag, "_latencia"}, n, 32'd8);
    chk({tag, "_suma"}, 32'(s8), 32'(es));
    chk({tag, "_acarreo"}, 32'(c8), 32'(ec));
    chk({tag, "_desb"}, 32'(v8), 32'(ev));
    tick();
    chk({tag, "_listo_pulso"}, 32'(ls8), 32'd0);
  endtask

  task automatic op16(input string tag, input logic r, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic [15:0] es, input logic ec, input logic ev);
    int n;
    resta16 = r; a16 = a; b16 = b; ci16 = ci; ini16 = 1'b1;
    tick();
    ini16 = 1'b0; a16 = ~a; b16 = ~b;
    wait16(n);
    chk({tag, "_latencia"}, n, 32'd4);
    chk({tag, "_suma"}, 32'(s16), 32'(es));
    chk({tag, "_acarreo"}, 32'(c16), 32'(ec));
    chk({tag, "_desb"}, 32'(v16), 32'(ev));
  endtask

  initial begin
    int n;
    int nlisto;
    logic [15:0] ra, rb, es;
    logic        rr, rci, ec, ev;
    int          sr;

    tick();
    tick();
    chk("rst_suma", 32'(s8), 32'd0);
    chk("rst_acarreo", 32'(c8), 32'd0);
    chk("rst_desb", 32'(v8), 32'd0);
    chk("rst_ocupado", 32'(oc8), 32'd0);
    chk("rst_listo", 32'(ls8), 32'd0);
    chk("rst_suma16", 32'(s16), 32'd0);
    rst = 1'b0;
    tick();

    op8("add_0F_01", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("add_FF_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add_7F_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("add_FF_FF_c", 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    op8("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    op8("sub_05_03_b", 1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0);
    op8("sub_00_80", 1'b1, 8'h00, 8'h80, 1'b0, 8'h80, 1'b0, 1'b1);

    // inicio held high with changing operands: only the first op counts,
    // then the op presented in the listo cycle is accepted at once.
    resta8 = 1'b0; a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; ini8 = 1'b1;
    tick();
    n = 0;
    do begin
      a8 = 8'h55 + 8'(n); b8 = 8'h66; ci8 = 1'b1;
      tick();
      n++;
    end while (!ls8 && n < 20);
    chk("hs_latencia", n, 32'd8);
    chk("hs_suma1", 32'(s8), 32'h30);
    chk("hs_ocupado_listo", 32'(oc8), 32'd0);
    a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0;
    tick();
    chk("hs_ocupado2", 32'(oc8), 32'd1);
    ini8 = 1'b0;
    wait8(n);
    chk("hs_latencia2", n, 32'd8);
    chk("hs_suma2", 32'(s8), 32'h03);

    // Reset while slice 4 is pending
    a8 = 8'h40; b8 = 8'h40; ini8 = 1'b1;
    tick();
    ini8 = 1'b0;
    repeat (4) tick();
    chk("mid_ocupado", 32'(oc8), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_suma", 32'(s8), 32'd0);
    chk("mid_acarreo", 32'(c8), 32'd0);
    chk("mid_desb", 32'(v8), 32'd0);
    chk("mid_ocupado0", 32'(oc8), 32'd0);
    nlisto = 0;
    repeat (12) begin
      tick();
      if (ls8) nlisto++;
    end
    chk("mid_sin_listo", nlisto, 32'd0);
    op8("post_rst_22_11", 1'b0, 8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

    op16("w16_FFFF_0001", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("w16_sub_0000_0001", 1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rr  = 1'($urandom_range(0, 1));
      rci = 1'($urandom_range(0, 1));
      if (!rr) begin
        {ec, es} = {1'b0, ra} + {1'b0, rb} + 17'(rci);
        sr = int'($signed(ra)) + int'($signed(rb)) + int'(rci);
      end else begin
        es = ra - rb - 16'(rci);
        ec = (int'(ra) >= int'(rb) + int'(rci));
        sr = int'($signed(ra)) - int'($signed(rb)) - int'(rci);
      end
      ev = (sr > 32767) || (sr < -32768);
      op16("rnd16", rr, ra, rb, rci, es, ec, ev);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
